// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - two-entry IF/ID skid buffer with flush and J-format target
// Holds {pc, pcplus4, inst} from fetch and hands them to decode in order.
module if_id_skid_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] NOP_INST = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_pcplus4,
  input  logic [WIDTH-1:0] in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pcplus4,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_jump_addr,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             push, pop;
  logic             load_head_in, load_head_tail, load_tail;
  logic [WIDTH-1:0] head_pc, head_pcplus4, head_inst;
  logic [WIDTH-1:0] tail_pc, tail_pcplus4, tail_inst;

  // in_ready looks only at registered occupancy so decode stalls never reach fetch.
  assign in_ready  = ~reset & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign count     = state;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_next   = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_next = FULL;
            load_tail  = 1'b1;
          end else if (push && pop) begin
            load_head_in = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next     = ONE;
            load_head_tail = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_pc      <= '0;
      head_pcplus4 <= '0;
      head_inst    <= NOP_INST;
      tail_pc      <= '0;
      tail_pcplus4 <= '0;
      tail_inst    <= NOP_INST;
    end else begin
      if (load_head_in) begin
        head_pc      <= in_pc;
        head_pcplus4 <= in_pcplus4;
        head_inst    <= in_inst;
      end else if (load_head_tail) begin
        head_pc      <= tail_pc;
        head_pcplus4 <= tail_pcplus4;
        head_inst    <= tail_inst;
      end
      if (load_tail) begin
        tail_pc      <= in_pc;
        tail_pcplus4 <= in_pcplus4;
        tail_inst    <= in_inst;
      end
    end
  end

  // An empty stage presents a nop so control decodes nothing harmful.
  assign out_pc        = out_valid ? head_pc      : '0;
  assign out_pcplus4   = out_valid ? head_pcplus4 : '0;
  assign out_inst      = out_valid ? head_inst    : NOP_INST;
  assign out_jump_addr = {out_pcplus4[WIDTH-1 -: 4], out_inst[25:0], 2'b00};

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - directed and random checks of if_id_skid_stage against a queue model
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h00000000;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_pcplus4, in_inst;
  logic [31:0] out_pc, out_pcplus4, out_inst, out_jump_addr;
  logic [1:0]  count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];

  if_id_skid_stage #(.WIDTH(32), .NOP_INST(NOP)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pcplus4(in_pcplus4), .in_inst(in_inst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pcplus4(out_pcplus4), .out_inst(out_inst), .out_jump_addr(out_jump_addr),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic cycle(input string tag, input logic rst, input logic iv, input logic orr,
                       input logic fl, input logic [31:0] pc, input logic [31:0] inst);
    ent_t  head;
    logic  ev, acc;
    reset = rst; in_valid = iv; out_ready = orr; flush = fl;
    in_pc = pc; in_pcplus4 = pc + 32'd4; in_inst = inst;
    #1;
    ev   = (q.size() != 0);
    head = ev ? q[0] : '{pc: 32'd0, pcp4: 32'd0, inst: NOP};
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!rst && q.size() < 2));
    chk({tag, ".out_pc"},    out_pc,         head.pc);
    chk({tag, ".out_pcp4"},  out_pcplus4,    head.pcp4);
    chk({tag, ".out_inst"},  out_inst,       head.inst);
    chk({tag, ".jump"},      out_jump_addr,  {head.pcp4[31:28], head.inst[25:0], 2'b00});
    @(posedge clock);
    if (rst || fl) begin
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      if (ev && orr) void'(q.pop_front());
      if (acc) q.push_back('{pc: pc, pcp4: pc + 32'd4, inst: inst});
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_pcplus4 = '0; in_inst = '0;
    @(posedge clock);
    @(negedge clock);
    cycle("rst", 1, 0, 0, 0, 32'h0, 32'h0);

    // Single beat, one-cycle latency
    cycle("t1_push", 0, 1, 1, 0, 32'h00400000, 32'h20080005);
    chk("t1_inst_lit", out_inst, 32'h20080005);
    chk("t1_pcp4_lit", out_pcplus4, 32'h00400004);
    chk("t1_count_lit", 32'(count), 32'd1);
    cycle("t1_drain", 0, 0, 1, 0, 32'h0, 32'h0);

    // Back-pressure: fill, hold third beat, then drain in order
    cycle("t2_a", 0, 1, 0, 0, 32'h00400000, 32'h11111111);
    cycle("t2_b", 0, 1, 0, 0, 32'h00400004, 32'h22222222);
    cycle("t2_c_held", 0, 1, 0, 0, 32'h00400008, 32'h33333333);
    chk("t2_in_ready_full", 32'(in_ready), 32'd0);
    cycle("t2_pop_a", 0, 1, 1, 0, 32'h00400008, 32'h33333333);
    cycle("t2_pop_b", 0, 1, 1, 0, 32'h00400008, 32'h33333333);
    chk("t2_head_c", out_pc, 32'h00400008);
    cycle("t2_pop_c", 0, 0, 1, 0, 32'h0, 32'h0);

    // Streaming
    for (int i = 0; i < 8; i++)
      cycle($sformatf("t3_%0d", i), 0, 1, 1, 0, 32'h00401000 + 32'(i * 4), $urandom);
    cycle("t3_drain", 0, 0, 1, 0, 32'h0, 32'h0);

    // Flush from FULL with a simultaneous beat and out_ready
    cycle("t4_a", 0, 1, 0, 0, 32'h00402000, 32'hAAAA0001);
    cycle("t4_b", 0, 1, 0, 0, 32'h00402004, 32'hAAAA0002);
    cycle("t4_flush", 0, 1, 1, 1, 32'h00402008, 32'hAAAA0003);
    chk("t4_inst_nop", out_inst, NOP);
    cycle("t4_after", 0, 0, 1, 0, 32'h0, 32'h0);

    // Jump target concatenation
    cycle("t5_a", 0, 1, 0, 0, 32'h00400000, 32'h0810000A);
    chk("t5_jump_a", out_jump_addr, 32'h00400028);
    cycle("t5_b", 0, 1, 1, 0, 32'hF0000000, 32'h0BFFFFFF);
    chk("t5_jump_b", out_jump_addr, 32'hFFFFFFFC);
    cycle("t5_drain", 0, 0, 1, 0, 32'h0, 32'h0);

    // Reset mid-stream from FULL
    cycle("t6_a", 0, 1, 0, 0, 32'h00403000, 32'hBBBB0001);
    cycle("t6_b", 0, 1, 0, 0, 32'h00403004, 32'hBBBB0002);
    cycle("t6_rst", 1, 1, 1, 0, 32'h00403008, 32'hBBBB0003);
    chk("t6_count_after", 32'(count), 32'd0);
    cycle("t6_after", 0, 0, 0, 0, 32'h0, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($sformatf("rnd_%0d", i), ($urandom_range(0, 63) == 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
            {$urandom} & 32'hFFFFFFFC, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
